// File: rtl/ex_branch_unit.sv
// Execute-stage branch resolver: target/condition evaluation, mispredict
// detection with fetch redirect, the fetch-side BHT and perf counters.
package ex_branch_pkg;

  typedef enum logic [1:0] {
    STALL_PASS = 2'd0,
    STALL_HOLD = 2'd1,
    STALL_BUBB = 2'd2
  } stall_e;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_BEQ  = 5'd1,
    OP_BNE  = 5'd2,
    OP_BLT  = 5'd3,
    OP_BGE  = 5'd4,
    OP_BLTU = 5'd5,
    OP_BGEU = 5'd6,
    OP_JAL  = 5'd7,
    OP_JALR = 5'd8,
    OP_ADD  = 5'd9
  } op_e;

endpackage

module ex_branch_unit
  import ex_branch_pkg::*;
#(
  parameter int BHT_IDX_W = 6,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  stall_e           stall_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      rs1_data_i,
  input  logic [31:0]      rs2_data_i,
  input  op_e              op_i,
  input  logic             branch_i,
  input  logic             jump_i,
  input  logic [31:0]      branch_addr_i,
  input  logic [31:0]      branch_offset_i,
  input  logic             predict_result_i,
  input  logic [31:0]      npc_i,
  output logic             branch_error_o,
  output logic [31:0]      redirect_pc_o,
  input  logic [31:0]      if_pc_i,
  output logic             if_predict_taken_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  localparam int BHT_N = 1 << BHT_IDX_W;

  logic [1:0]           bht [BHT_N];
  logic [BHT_IDX_W-1:0] upd_idx;
  logic [BHT_IDX_W-1:0] rd_idx;
  logic [31:0]          sum;
  logic [31:0]          target;
  logic [31:0]          actual_next;
  logic                 cond;
  logic                 taken;
  logic                 commit;
  logic                 eq;
  logic                 lt_s;
  logic                 lt_u;
  logic [1:0]           cur;
  logic [1:0]           nxt;

  // The prediction bit is only needed by fetch; the BHT itself is
  // the source of truth for history.
  logic unused_ok;
  assign unused_ok = ^{predict_result_i,
                       if_pc_i[31:BHT_IDX_W+2],
                       if_pc_i[1:0]};

  assign upd_idx = pc_i[BHT_IDX_W+1:2];
  assign rd_idx  = if_pc_i[BHT_IDX_W+1:2];
  assign commit  = (stall_i == STALL_PASS);

  assign eq   = (rs1_data_i == rs2_data_i);
  assign lt_s = ($signed(rs1_data_i) < $signed(rs2_data_i));
  assign lt_u = (rs1_data_i < rs2_data_i);

  always_comb begin
    cond = 1'b0;
    unique case (op_i)
      OP_BEQ:  cond = eq;
      OP_BNE:  cond = ~eq;
      OP_BLT:  cond = lt_s;
      OP_BGE:  cond = ~lt_s;
      OP_BLTU: cond = lt_u;
      OP_BGEU: cond = ~lt_u;
      default: cond = 1'b0;
    endcase
  end

  assign sum    = branch_addr_i + branch_offset_i;
  assign target = (op_i == OP_JALR) ? {sum[31:1], 1'b0} : sum;
  assign taken  = jump_i | (branch_i & cond);

  assign actual_next = taken ? target : pc_i + 32'd4;

  assign branch_error_o = (branch_i | jump_i)
                        & (actual_next != npc_i)
                        & ~rst
                        & (stall_i != STALL_BUBB);

  assign redirect_pc_o = branch_error_o ? actual_next : 32'd0;

  assign if_predict_taken_o = ~rst & bht[rd_idx][1];

  assign cur = bht[upd_idx];

  always_comb begin
    nxt = cur;
    if (cond) begin
      if (cur != 2'b11) nxt = cur + 2'd1;
    end else begin
      if (cur != 2'b00) nxt = cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
    end else if (commit && branch_i) begin
      bht[upd_idx] <= nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_o     <= '0;
      mispredict_cnt_o <= '0;
    end else if (commit) begin
      if (branch_i | jump_i)
        branch_cnt_o <= branch_cnt_o + CNT_W'(1);
      if (branch_error_o)
        mispredict_cnt_o <= mispredict_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: doc/ex_branch_unit.md
Name: ex_branch_unit

Overview:
- Execute-stage branch resolver that directly consumes the branch and prediction fields leaving the ID/EX pipeline register.
- Computes the actual next PC for conditional branches, JAL and JALR, and compares it with the PC that fetch actually issued (npc).
- On a mismatch it raises branch_error, which flushes the IF/ID and ID/EX registers, and supplies redirect_pc to fetch.
- Owns the 2-bit saturating branch history table (BHT) that fetch reads for predictions; also keeps branch and mispredict counters.

Parameters:
- BHT_IDX_W, 6, log2 of BHT entries (64 entries); index is pc[BHT_IDX_W+1:2].
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall_i  in  `StallBus  EX-stage stall code; only `Pass commits state
- pc_i  in  `InstAddrBus  PC of the instruction in EX
- rs1_data_i  in  `RegBus  operand 1 (forwarded)
- rs2_data_i  in  `RegBus  operand 2 (forwarded)
- op_i  in  `OpBus  operation; branch ops are `OpBeq/`OpBne/`OpBlt/`OpBge/`OpBltu/`OpBgeu/`OpJal/`OpJalr
- branch_i  in  1  conditional branch
- jump_i  in  1  JAL/JALR
- branch_addr_i  in  `InstAddrBus  target base (pc for branch/JAL, rs1 for JALR)
- branch_offset_i  in  `InstAddrBus  sign-extended offset
- predict_result_i  in  1  fetch predicted taken
- npc_i  in  `InstAddrBus  PC fetch issued after pc_i
- branch_error_o  out  1  mispredict; flush younger stages
- redirect_pc_o  out  `InstAddrBus  correct next PC, valid when branch_error_o=1
- if_pc_i  in  `InstAddrBus  fetch PC for BHT lookup
- if_predict_taken_o  out  1  BHT prediction for if_pc_i
- branch_cnt_o  out  CNT_W  committed branch+jump count
- mispredict_cnt_o  out  CNT_W  committed mispredict count

Behaviour:
- Resolution (combinational):
  - target = branch_addr_i + branch_offset_i, mod 2^32; for `OpJalr, bit 0 of the target is cleared.
  - Conditions: BEQ/BNE use ==/!=; BLT/BGE use signed compare; BLTU/BGEU use unsigned compare. Jumps are always taken.
  - actual_next = taken ? target : pc_i + 4.
- Error generation:
  - branch_error_o = (branch_i | jump_i) & (actual_next != npc_i) & ~rst & (stall_i != `Bubb).
  - redirect_pc_o = actual_next when branch_error_o=1, else 0.
  - An instruction with branch_i=jump_i=0 never raises an error, even if npc_i differs from pc_i+4.
  - The error may assert while stall_i=`Hold; the downstream flush is idempotent.
- BHT: 2^BHT_IDX_W 2-bit counters.
  - if_predict_taken_o = bht[if_pc_i[BHT_IDX_W+1:2]][1], purely combinational.
  - Update at posedge only when stall_i==`Pass and branch_i=1, at index pc_i[BHT_IDX_W+1:2].
  - Taken: counter increments, saturating at 3. Not taken: counter decrements, saturating at 0.
  - Jumps do not update the BHT.
  - A same-cycle read and update of the same index returns the pre-update value.
- Counters:
  - On posedge with stall_i==`Pass: branch_cnt increments if branch_i|jump_i; mispredict_cnt increments if branch_error_o.
  - Both counters wrap modulo 2^CNT_W.
  - A `Hold cycle never updates the BHT or the counters, so an instruction held for N cycles commits exactly once.
- Reset (synchronous):
  - All BHT entries are set to 2'b01 (weakly not-taken); both counters are set to 0.
  - Combinational outputs are forced to 0 while rst=1.
  - Reset asserted during a held instruction discards that instruction's pending update.
- Simultaneous events: rst dominates branch_error. Mispredict and BHT update happen in the same cycle.

Test Plan:
1. Reset, then read any if_pc -> if_predict_taken_o=0; counters=0; branch_error_o=0.
2. BEQ, pc=0x100, rs1=rs2=5, base=0x100, off=0x20, npc=0x104, predicted 0, Pass -> branch_error_o=1, redirect_pc_o=0x120; next cycle bht[0]=2, if_pc=0x100 predicts 1, mispredict_cnt=1, branch_cnt=1.
3. JALR, base=0x2003, off=4, npc=0x2006 -> redirect 0x2006 with bit 0 cleared = 0x2006, no error; with npc=0x2008 -> error, redirect_pc_o=0x2006.
4. BLT, rs1=0xFFFFFFFF, rs2=1 -> taken (signed); BLTU with the same operands -> not taken; check error against npc in each case.
5. BNE taken held with stall_i=`Hold for 3 cycles, then `Pass -> branch_cnt increments by 1 only; the BHT entry moves by one step only.
6. Four taken updates at the same index -> counter saturates at 3; five not-taken updates -> saturates at 0. rst asserted mid-sequence -> entry returns to 1 and counters return to 0.
